// File: rtl/bomb_timer_scheduler.sv
// Multi-slot bomb countdown scheduler with a single round-robin pause token.
// Optional macro BOMB_CHAIN_EN: any explosion clamps other live slots to 3 seconds.
//   state     | meaning
//   S_IDLE    | never armed since reset
//   S_RUN     | counting down on OneSecPulse
//   S_PAUSE   | holds the pause token, remaining frozen
//   S_EXPLODE | timer expired
//   S_SAVE    | defused, remaining frozen at defuse value
module bomb_timer_scheduler #(
  parameter int NUM_BOMBS  = 4,
  parameter int TIME_W     = 6,
  parameter int ARM_TIME   = 30,
  parameter int PAUSE_SECS = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        OneSecPulse,
  input  logic [NUM_BOMBS-1:0]        arm_req,
  input  logic [NUM_BOMBS-1:0]        pause_req,
  input  logic [NUM_BOMBS-1:0]        save_req,
  output logic [NUM_BOMBS*TIME_W-1:0] remaining,
  output logic [NUM_BOMBS-1:0]        running,
  output logic [NUM_BOMBS-1:0]        paused,
  output logic [NUM_BOMBS-1:0]        exploded,
  output logic [NUM_BOMBS-1:0]        saved,
  output logic [NUM_BOMBS-1:0]        explode_pulse,
  output logic                        pause_busy,
  output logic [2:0]                  pause_owner
);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_PAUSE, S_EXPLODE, S_SAVE} state_t;

  state_t              r_state [NUM_BOMBS];
  logic [TIME_W-1:0]   r_rem   [NUM_BOMBS];
  logic [NUM_BOMBS-1:0] r_xpl;
  logic [3:0]          r_pcnt;
  logic                r_busy;
  logic [2:0]          r_owner;
  logic [2:0]          r_ptr;

  logic [NUM_BOMBS-1:0]   w_expire;
  logic [NUM_BOMBS-1:0]   w_elig;
  logic [NUM_BOMBS-1:0]   w_rot;
  logic [2*NUM_BOMBS-1:0] w_dbl;
  logic [NUM_BOMBS-1:0]   w_gnt;
  logic [2:0]             w_off;
  logic [3:0]             w_sum;
  logic [2:0]             w_gnt_idx;
  logic [2:0]             w_ptr_nxt;
  logic                   w_gnt_vld;
  logic                   w_release;

  // Slots that are saving or expiring this cycle are not offered the token.
  always_comb begin
    w_release = 1'b0;
    for (int i = 0; i < NUM_BOMBS; i++) begin
      w_expire[i] = (r_state[i] == S_RUN) && !save_req[i] && OneSecPulse &&
                    (r_rem[i] == TIME_W'(1));
      w_elig[i]   = (r_state[i] == S_RUN) && pause_req[i] && !save_req[i] && !w_expire[i];
      if ((r_state[i] == S_PAUSE) && (save_req[i] || (OneSecPulse && r_pcnt == 4'd1)))
        w_release = 1'b1;
    end
    w_dbl = {w_elig, w_elig} >> r_ptr;
    w_rot = w_dbl[NUM_BOMBS-1:0];
    w_off = '0;
    for (int k = NUM_BOMBS-1; k >= 0; k--) begin
      if (w_rot[k]) w_off = 3'(k);
    end
    w_sum = {1'b0, r_ptr} + {1'b0, w_off};
    if (w_sum >= 4'(NUM_BOMBS)) w_sum = w_sum - 4'(NUM_BOMBS);
    w_gnt_idx = w_sum[2:0];
    w_gnt_vld = !r_busy && (|w_elig);
    w_ptr_nxt = (w_gnt_idx == 3'(NUM_BOMBS-1)) ? 3'd0 : w_gnt_idx + 3'd1;
    for (int j = 0; j < NUM_BOMBS; j++) begin
      w_gnt[j] = w_gnt_vld && (w_gnt_idx == 3'(j));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_BOMBS; i++) begin
        r_state[i] <= S_IDLE;
        r_rem[i]   <= '0;
      end
      r_xpl   <= '0;
      r_pcnt  <= '0;
      r_busy  <= 1'b0;
      r_owner <= '0;
      r_ptr   <= '0;
    end else begin
      for (int i = 0; i < NUM_BOMBS; i++) begin
        r_xpl[i] <= w_expire[i];
        case (r_state[i])
          S_RUN: begin
            if (save_req[i]) begin
              r_state[i] <= S_SAVE;
            end else if (w_expire[i]) begin
              r_state[i] <= S_EXPLODE;
              r_rem[i]   <= '0;
            end else if (w_gnt[i]) begin
              r_state[i] <= S_PAUSE;
            end else if (OneSecPulse && r_rem[i] != '0) begin
              r_rem[i] <= r_rem[i] - 1'b1;
            end
          end
          S_PAUSE: begin
            if (save_req[i]) r_state[i] <= S_SAVE;
            else if (OneSecPulse && r_pcnt == 4'd1) r_state[i] <= S_RUN;
          end
          default: begin
            if (arm_req[i]) begin
              r_state[i] <= S_RUN;
              r_rem[i]   <= TIME_W'(ARM_TIME);
            end
          end
        endcase
`ifdef BOMB_CHAIN_EN
        // Later assignment wins over the per-state update above.
        if ((|w_expire) && !w_expire[i] && (r_state[i] == S_RUN || r_state[i] == S_PAUSE) &&
            r_rem[i] > TIME_W'(3))
          r_rem[i] <= TIME_W'(3);
`endif
      end

      if (w_gnt_vld) begin
        r_busy  <= 1'b1;
        r_owner <= w_gnt_idx;
        r_pcnt  <= 4'(PAUSE_SECS);
        r_ptr   <= w_ptr_nxt;
      end else if (w_release) begin
        r_busy  <= 1'b0;
        r_owner <= '0;
        r_pcnt  <= '0;
      end else if (r_busy && OneSecPulse) begin
        r_pcnt <= r_pcnt - 4'd1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_BOMBS; i++) begin
      remaining[i*TIME_W +: TIME_W] = r_rem[i];
      running[i]  = (r_state[i] == S_RUN);
      paused[i]   = (r_state[i] == S_PAUSE);
      exploded[i] = (r_state[i] == S_EXPLODE);
      saved[i]    = (r_state[i] == S_SAVE);
    end
    explode_pulse = r_xpl;
    pause_busy    = r_busy;
    pause_owner   = r_owner;
  end

endmodule

// File: tb/tb_bomb_timer_scheduler.sv
// Self-checking bench for bomb_timer_scheduler: directed scenarios plus random traffic
// compared every cycle against a slot-level behavioural model.
module tb_bomb_timer_scheduler;
  localparam int N = 4;
  localparam int TW = 6;
  localparam int ARM = 30;
  localparam int PS = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic OneSecPulse = 1'b0;
  logic [N-1:0] arm_req = '0, pause_req = '0, save_req = '0;
  logic [N*TW-1:0] remaining;
  logic [N-1:0] running, paused, exploded, saved, explode_pulse;
  logic pause_busy;
  logic [2:0] pause_owner;

  bomb_timer_scheduler #(.NUM_BOMBS(N), .TIME_W(TW), .ARM_TIME(ARM), .PAUSE_SECS(PS)) dut (
    .clk(clk), .reset(reset), .OneSecPulse(OneSecPulse),
    .arm_req(arm_req), .pause_req(pause_req), .save_req(save_req),
    .remaining(remaining), .running(running), .paused(paused), .exploded(exploded),
    .saved(saved), .explode_pulse(explode_pulse), .pause_busy(pause_busy),
    .pause_owner(pause_owner));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: slot mode 0 idle, 1 run, 2 pause, 3 exploded, 4 saved; owner -1 = token free.
  int m_mode [N];
  int m_rem [N];
  bit m_xp [N];
  int m_owner, m_pleft, m_next;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_mode[i] = 0; m_rem[i] = 0; m_xp[i] = 0;
    end
    m_owner = -1; m_pleft = 0; m_next = 0;
  endtask

  task automatic model_step(input bit pulse, input logic [N-1:0] a, p, s);
    int nmode [N];
    int nrem [N];
    int win;
    bit freed;
    bit any_boom;
    win = -1; freed = 0; any_boom = 0;
    if (m_owner < 0)
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_next + k) % N;
        if (win < 0 && m_mode[j] == 1 && p[j] && !s[j] && !(pulse && m_rem[j] == 1)) win = j;
      end
    for (int i = 0; i < N; i++) begin
      nmode[i] = m_mode[i]; nrem[i] = m_rem[i]; m_xp[i] = 0;
      if (m_mode[i] == 1) begin
        if (s[i]) nmode[i] = 4;
        else if (pulse && m_rem[i] == 1) begin nmode[i] = 3; nrem[i] = 0; m_xp[i] = 1; any_boom = 1; end
        else if (i == win) nmode[i] = 2;
        else if (pulse && m_rem[i] > 0) nrem[i] = m_rem[i] - 1;
      end else if (m_mode[i] == 2) begin
        if (s[i]) begin nmode[i] = 4; freed = 1; end
        else if (pulse && m_pleft == 1) begin nmode[i] = 1; freed = 1; end
      end else if (a[i]) begin
        nmode[i] = 1; nrem[i] = ARM;
      end
    end
`ifdef BOMB_CHAIN_EN
    if (any_boom)
      for (int i = 0; i < N; i++)
        if (!m_xp[i] && (m_mode[i] == 1 || m_mode[i] == 2) && m_rem[i] > 3) nrem[i] = 3;
`endif
    if (win >= 0) begin m_owner = win; m_pleft = PS; m_next = (win + 1) % N; end
    else if (freed) begin m_owner = -1; m_pleft = 0; end
    else if (m_owner >= 0 && pulse) m_pleft = m_pleft - 1;
    for (int i = 0; i < N; i++) begin m_mode[i] = nmode[i]; m_rem[i] = nrem[i]; end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, got, exp);
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < N; i++) begin
      chk($sformatf("remaining[%0d]", i), 32'(remaining[i*TW +: TW]), 32'(m_rem[i]));
      chk($sformatf("running[%0d]", i), 32'(running[i]), 32'(m_mode[i] == 1));
      chk($sformatf("paused[%0d]", i), 32'(paused[i]), 32'(m_mode[i] == 2));
      chk($sformatf("exploded[%0d]", i), 32'(exploded[i]), 32'(m_mode[i] == 3));
      chk($sformatf("saved[%0d]", i), 32'(saved[i]), 32'(m_mode[i] == 4));
      chk($sformatf("explode_pulse[%0d]", i), 32'(explode_pulse[i]), 32'(m_xp[i]));
    end
    chk("pause_busy", 32'(pause_busy), 32'(m_owner >= 0));
    chk("pause_owner", 32'(pause_owner), (m_owner < 0) ? 32'd0 : 32'(m_owner));
  endtask

  // Called at a negedge; drives one cycle and checks the result at the next negedge.
  task automatic tick(input bit pulse, input logic [N-1:0] a, p, s);
    OneSecPulse = pulse; arm_req = a; pause_req = p; save_req = s;
    @(posedge clk);
    model_step(pulse, a, p, s);
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    reset = 1'b1; OneSecPulse = 0; arm_req = '0; pause_req = '0; save_req = '0;
    model_reset();
    @(negedge clk); @(negedge clk);
    compare_all();
    reset = 1'b0;
  endtask

  initial begin
    model_reset();
    do_reset();
    chk("reset running", 32'(running), 32'd0);
    chk("reset remaining", 32'(remaining), 32'd0);

    // Arm slot 0 and run it to expiry.
    tick(0, 4'b0001, 0, 0);
    chk("arm running", 32'(running), 32'b0001);
    chk("arm remaining0", 32'(remaining[TW-1:0]), 32'd30);
    for (int c = 0; c < 29; c++) tick(1, 0, 0, 0);
    chk("rem0 before expiry", 32'(remaining[TW-1:0]), 32'd1);
    tick(1, 0, 0, 0);
    chk("exploded0", 32'(exploded), 32'b0001);
    chk("explode_pulse0 high", 32'(explode_pulse), 32'b0001);
    chk("rem0 after expiry", 32'(remaining[TW-1:0]), 32'd0);
    tick(0, 0, 0, 0);
    chk("explode_pulse0 low", 32'(explode_pulse), 32'b0000);

    // Pause token handoff between slots 0 and 1.
    tick(0, 4'b0011, 0, 0);
    tick(0, 0, 4'b0011, 0);
    chk("first grant paused", 32'(paused), 32'b0001);
    chk("first grant owner", 32'(pause_owner), 32'd0);
    for (int c = 0; c < 3; c++) tick(1, 0, 4'b0011, 0);
    chk("release running", 32'(running), 32'b0011);
    chk("release busy", 32'(pause_busy), 32'd0);
    tick(0, 0, 4'b0011, 0);
    chk("second grant paused", 32'(paused), 32'b0010);
    chk("second grant owner", 32'(pause_owner), 32'd1);
    for (int c = 0; c < 3; c++) tick(1, 0, 0, 0);
    tick(0, 0, 0, 4'b0011);

    // Pause and pulse in the same cycle on slot 2 at remaining 5.
    tick(0, 4'b0100, 0, 0);
    for (int c = 0; c < 25; c++) tick(1, 0, 0, 0);
    tick(1, 0, 4'b0100, 0);
    chk("pause drop paused", 32'(paused), 32'b0100);
    chk("pause drop rem2", 32'(remaining[2*TW +: TW]), 32'd5);
    for (int c = 0; c < 3; c++) tick(1, 0, 0, 0);
    chk("after pause rem2", 32'(remaining[2*TW +: TW]), 32'd5);
    chk("after pause running2", 32'(running[2]), 32'd1);
    tick(0, 0, 0, 4'b0100);

    // Save beats expiry on slot 1.
    tick(0, 4'b0010, 0, 0);
    for (int c = 0; c < 29; c++) tick(1, 0, 0, 0);
    tick(1, 0, 0, 4'b0010);
    chk("save wins saved1", 32'(saved[1]), 32'd1);
    chk("save wins rem1", 32'(remaining[TW +: TW]), 32'd1);
    chk("save wins no pulse", 32'(explode_pulse), 32'd0);

    // Asynchronous reset while slot 3 holds the token.
    tick(0, 4'b1000, 0, 0);
    tick(0, 0, 4'b1000, 0);
    chk("slot3 paused", 32'(paused), 32'b1000);
    #2 reset = 1'b1;
    #1;
    chk("async rst paused", 32'(paused), 32'd0);
    chk("async rst busy", 32'(pause_busy), 32'd0);
    chk("async rst saved", 32'(saved), 32'd0);
    chk("async rst remaining", 32'(remaining), 32'd0);
    do_reset();

`ifdef BOMB_CHAIN_EN
    tick(0, 4'b0001, 0, 0);
    tick(1, 0, 0, 0);
    tick(0, 4'b0100, 0, 0);
    for (int c = 0; c < 18; c++) tick(1, 0, 0, 0);
    tick(0, 4'b0010, 0, 0);
    for (int c = 0; c < 10; c++) tick(1, 0, 0, 0);
    tick(0, 0, 4'b0100, 0);
    tick(1, 0, 0, 0);
    chk("chain rem1", 32'(remaining[TW +: TW]), 32'd3);
    chk("chain rem2", 32'(remaining[2*TW +: TW]), 32'd2);
    do_reset();
`endif

    // Random traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      logic [N-1:0] a, p, s;
      for (int i = 0; i < N; i++) begin
        a[i] = ($urandom_range(0, 15) == 0);
        p[i] = ($urandom_range(0, 2) == 0);
        s[i] = ($urandom_range(0, 40) == 0);
      end
      tick($urandom_range(0, 3) == 0, a, p, s);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
